multicycle_control: RTL

//  Multicycle MIPS control FSM; initiator on the ALU control interface. Per state it drives

---
 rtl/multicycle_control_pkg.sv | 59 +++++
 rtl/multicycle_control_alu_op_decoder.sv | 30 +++
 rtl/multicycle_control.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU ops, opcodes,
// funct codes, mux select codes and FSM state encodings.
package multicycle_control_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_SLLI = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_RS = 2'b01;
  localparam logic [1:0] SRCA_RT = 2'b10;

  localparam logic [2:0] SRCB_REGB    = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_SIMM    = 3'b010;
  localparam logic [2:0] SRCB_SIMM_SH = 3'b011;
  localparam logic [2:0] SRCB_ZIMM    = 3'b100;
  localparam logic [2:0] SRCB_SHAMT   = 3'b101;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_IMM_EX   = 4'd9,
    S_IMM_WB   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

endpackage

// File: rtl/multicycle_control_alu_op_decoder.sv
// R-type funct decoder: ALU operation, shift-operand flag and legality.
// Purely combinational.
module alu_op_decoder
  import multicycle_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       is_shift,
  output logic       legal
);

  always_comb begin
    alu_op   = ALU_AND;
    is_shift = 1'b0;
    legal    = 1'b1;
    case (funct)
      FN_ADD: alu_op = ALU_ADD;
      FN_SUB: alu_op = ALU_SUB;
      FN_AND: alu_op = ALU_AND;
      FN_OR:  alu_op = ALU_OR;
      FN_NOR: alu_op = ALU_NOR;
      FN_SLL: begin
        alu_op   = ALU_SLLI;
        is_shift = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: Moore-decoded datapath controls per state,
// with the branch PC write qualified combinationally by the ALU Zero flag.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [2:0] ALUOperation,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       IllegalInstr
);

  state_t     state, next_state;
  logic [2:0] fn_op;
  logic       fn_shift, fn_legal;

  alu_op_decoder u_dec (
    .funct    (Funct),
    .alu_op   (fn_op),
    .is_shift (fn_shift),
    .legal    (fn_legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RESET;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_RESET;
    case (state)
      S_RESET:  next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:     next_state = S_MEMADDR;
          OP_RTYPE:         next_state = fn_legal ? S_RTYPE_EX : S_FETCH;
          OP_ADDI, OP_ORI:  next_state = S_IMM_EX;
          OP_BEQ, OP_BNE:   next_state = S_BRANCH;
          OP_J:             next_state = S_JUMP;
          default:          next_state = S_FETCH;
        endcase
      end
      S_MEMADDR:  next_state = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = S_FETCH;
      S_RTYPE_EX: next_state = S_RTYPE_WB;
      S_RTYPE_WB: next_state = S_FETCH;
      S_IMM_EX:   next_state = S_IMM_WB;
      S_IMM_WB:   next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      default:    next_state = S_RESET;
    endcase
  end

  always_comb begin
    ALUOperation = ALU_AND;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_REGB;
    PCSource     = PCSRC_ALU;
    PCWrite      = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    MemtoReg     = 1'b0;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    IllegalInstr = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead      = 1'b1;
        IRWrite      = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ALUOperation = ALU_ADD;
        PCWrite      = 1'b1;
      end
      S_DECODE: begin
        // Branch target is computed speculatively for every opcode.
        ALUSrcB      = SRCB_SIMM_SH;
        ALUOperation = ALU_ADD;
        case (Opcode)
          OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_BEQ, OP_BNE, OP_J: IllegalInstr = 1'b0;
          OP_RTYPE: IllegalInstr = !fn_legal;
          default:  IllegalInstr = 1'b1;
        endcase
      end
      S_MEMADDR: begin
        ALUSrcA      = SRCA_RS;
        ALUSrcB      = SRCB_SIMM;
        ALUOperation = ALU_ADD;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_RTYPE_EX: begin
        ALUOperation = fn_op;
        ALUSrcA      = fn_shift ? SRCA_RT : SRCA_RS;
        ALUSrcB      = fn_shift ? SRCB_SHAMT : SRCB_REGB;
      end
      S_RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_IMM_EX: begin
        ALUSrcA      = SRCA_RS;
        ALUSrcB      = (Opcode == OP_ORI) ? SRCB_ZIMM : SRCB_SIMM;
        ALUOperation = (Opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_IMM_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA      = SRCA_RS;
        ALUSrcB      = SRCB_REGB;
        ALUOperation = ALU_SUB;
        PCSource     = PCSRC_ALUOUT;
        PCWrite      = (Opcode == OP_BNE) ? !Zero : Zero;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
